// File: rtl/tlb_pkg.sv
// Shared definitions for the CP0 TLB maintenance sequencer: op encodings,
// the 86-bit TLB entry layout and the CP0 <-> entry conversion helpers.
package tlb_pkg;

    localparam int TLB_ENTRIES_DEF = 16;
    localparam int TLB_WIDTH_DEF   = 4;
    localparam int ENTRY_W         = 86;

    // Entry field positions
    localparam int ASID_HI = 85;
    localparam int ASID_LO = 78;
    localparam int G_BIT   = 77;
    localparam int VPN2_HI = 70;
    localparam int VPN2_LO = 52;
    localparam int ODD_HI  = 51;   // {PFN1,C1,D1,V1}
    localparam int ODD_LO  = 27;
    localparam int EVEN_HI = 25;   // {PFN0,C0,D0,V0}
    localparam int EVEN_LO = 1;

    typedef enum logic [1:0] {
        OP_TLBR  = 2'd0,
        OP_TLBWI = 2'd1,
        OP_TLBWR = 2'd2,
        OP_TLBP  = 2'd3
    } tlb_op_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } tlb_cp0_t;

    // CP0 EntryHi/EntryLo0/EntryLo1 -> TLB entry; G is the AND of both pages.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] hi,
                                                      input logic [31:0] lo0,
                                                      input logic [31:0] lo1);
        logic [ENTRY_W-1:0] e;
        e                  = {ENTRY_W{1'b0}};
        e[ASID_HI:ASID_LO] = hi[7:0];
        e[G_BIT]           = lo0[0] & lo1[0];
        e[VPN2_HI:VPN2_LO] = hi[31:13];
        e[ODD_HI:ODD_LO]   = lo1[25:1];
        e[EVEN_HI:EVEN_LO] = lo0[25:1];
        return e;
    endfunction

    // TLB entry -> CP0 EntryHi/EntryLo0/EntryLo1; G is replicated into both.
    function automatic tlb_cp0_t unpack_entry(input logic [ENTRY_W-1:0] e);
        tlb_cp0_t r;
        r.hi  = {e[VPN2_HI:VPN2_LO], 5'b00000, e[ASID_HI:ASID_LO]};
        r.lo0 = {6'b000000, e[EVEN_HI:EVEN_LO], e[G_BIT]};
        r.lo1 = {6'b000000, e[ODD_HI:ODD_LO], e[G_BIT]};
        return r;
    endfunction

endpackage

// File: rtl/tlb_random.sv
// CP0 Random register: free-running down-counter that wraps from Wired
// back to the top entry, and restarts at the top whenever Wired is written.
module tlb_random
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = TLB_ENTRIES_DEF,
    parameter int TLB_WIDTH   = TLB_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          wired,
    input  logic                 wired_we,
    output logic [TLB_WIDTH-1:0] random
);

    localparam logic [TLB_WIDTH-1:0] RAND_TOP = TLB_WIDTH'(TLB_ENTRIES - 1);

    logic [TLB_WIDTH-1:0] wired_eff_s;
    logic [TLB_WIDTH-1:0] random_d;
    logic [TLB_WIDTH-1:0] random_q;

    // Clamp out-of-range Wired values to the last entry, then pick the next count.
    always_comb begin
        wired_eff_s = RAND_TOP;
        random_d    = random_q;
        if (wired >= 32'(TLB_ENTRIES)) begin
            wired_eff_s = RAND_TOP;
        end else begin
            wired_eff_s = wired[TLB_WIDTH-1:0];
        end
        if (wired_we) begin
            random_d = RAND_TOP;
        end else if (random_q == wired_eff_s) begin
            random_d = RAND_TOP;
        end else begin
            random_d = random_q - {{(TLB_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Random state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            random_q <= RAND_TOP;
        end else begin
            random_q <= random_d;
        end
    end

    assign random = random_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLBR/TLBWI/TLBWR/TLBP sequencer between CP0 and the TLB array.
// IDLE latches the op, EXEC arms the array strobe (visible while in WB),
// WB captures the probe/read result (write-back visible back in IDLE).
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = TLB_ENTRIES_DEF,
    parameter int TLB_WIDTH   = TLB_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [1:0]           op_type,
    output logic                 op_ready,
    output logic                 op_done,
    input  logic [31:0]          cp0_entryhi,
    input  logic [31:0]          cp0_entrylo0,
    input  logic [31:0]          cp0_entrylo1,
    input  logic [31:0]          cp0_index,
    input  logic [31:0]          cp0_wired,
    input  logic                 cp0_wired_we,
    output logic [31:0]          random_o,
    output logic [85:0]          tlb_config,
    output logic [TLB_WIDTH-1:0] tlb_config_index,
    output logic                 tlb_we,
    output logic                 tlb_p,
    input  logic [31:0]          tlb_p_res,
    output logic [TLB_WIDTH-1:0] tlb_rd_index,
    input  logic [85:0]          tlb_rd_entry,
    output logic                 index_we,
    output logic [31:0]          index_wdata,
    output logic                 entry_we,
    output logic [31:0]          entryhi_wdata,
    output logic [31:0]          entrylo0_wdata,
    output logic [31:0]          entrylo1_wdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    state_e               state_d, state_q;
    tlb_op_e              op_d, op_q;
    logic [85:0]          config_d, config_q;
    logic [TLB_WIDTH-1:0] index_d, index_q;
    logic                 op_ready_d, op_ready_q;
    logic                 op_done_d, op_done_q;
    logic                 tlb_we_d, tlb_we_q;
    logic                 tlb_p_d, tlb_p_q;
    logic                 index_we_d, index_we_q;
    logic                 entry_we_d, entry_we_q;
    logic [31:0]          index_wdata_d, index_wdata_q;
    logic [31:0]          entryhi_wdata_d, entryhi_wdata_q;
    logic [31:0]          entrylo0_wdata_d, entrylo0_wdata_q;
    logic [31:0]          entrylo1_wdata_d, entrylo1_wdata_q;

    logic [TLB_WIDTH-1:0] random_s;
    tlb_cp0_t             rd_unpacked_s;
    logic                 probe_miss_s;
    logic                 unused_ok_s;

    tlb_random #(
        .TLB_ENTRIES (TLB_ENTRIES),
        .TLB_WIDTH   (TLB_WIDTH)
    ) u_random (
        .clk      (clk),
        .rst      (rst),
        .wired    (cp0_wired),
        .wired_we (cp0_wired_we),
        .random   (random_s)
    );

    assign rd_unpacked_s = unpack_entry(tlb_rd_entry);
    assign probe_miss_s  = tlb_p_res[31];
    assign unused_ok_s   = ^{cp0_index[31:TLB_WIDTH], tlb_p_res[30:TLB_WIDTH]};

    // Next-state and next-output logic; everything holds unless the state says otherwise.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        config_d         = config_q;
        index_d          = index_q;
        op_ready_d       = 1'b0;
        op_done_d        = 1'b0;
        tlb_we_d         = 1'b0;
        tlb_p_d          = 1'b0;
        index_we_d       = 1'b0;
        entry_we_d       = 1'b0;
        index_wdata_d    = index_wdata_q;
        entryhi_wdata_d  = entryhi_wdata_q;
        entrylo0_wdata_d = entrylo0_wdata_q;
        entrylo1_wdata_d = entrylo1_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    op_d     = tlb_op_e'(op_type);
                    config_d = pack_entry(cp0_entryhi, cp0_entrylo0, cp0_entrylo1);
                    if (tlb_op_e'(op_type) == OP_TLBWR) begin
                        index_d = random_s;
                    end else begin
                        index_d = cp0_index[TLB_WIDTH-1:0];
                    end
                    state_d    = ST_EXEC;
                    op_ready_d = 1'b0;
                end else begin
                    state_d    = ST_IDLE;
                    op_ready_d = 1'b1;
                end
            end
            ST_EXEC: begin
                tlb_we_d = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);
                tlb_p_d  = (op_q == OP_TLBP);
                state_d  = ST_WB;
            end
            ST_WB: begin
                op_done_d  = 1'b1;
                op_ready_d = 1'b1;
                state_d    = ST_IDLE;
                if (op_q == OP_TLBP) begin
                    index_we_d = 1'b1;
                    if (probe_miss_s) begin
                        index_wdata_d = {1'b1, 31'd0};
                    end else begin
                        index_wdata_d = {1'b0, {(31-TLB_WIDTH){1'b0}}, tlb_p_res[TLB_WIDTH-1:0]};
                    end
                end else if (op_q == OP_TLBR) begin
                    entry_we_d       = 1'b1;
                    entryhi_wdata_d  = rd_unpacked_s.hi;
                    entrylo0_wdata_d = rd_unpacked_s.lo0;
                    entrylo1_wdata_d = rd_unpacked_s.lo1;
                end else begin
                    index_we_d = 1'b0;
                    entry_we_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                op_ready_d = 1'b1;
            end
        endcase
    end

    // State, latched request and registered outputs; reset drops any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            op_q             <= OP_TLBR;
            config_q         <= 86'd0;
            index_q          <= {TLB_WIDTH{1'b0}};
            op_ready_q       <= 1'b1;
            op_done_q        <= 1'b0;
            tlb_we_q         <= 1'b0;
            tlb_p_q          <= 1'b0;
            index_we_q       <= 1'b0;
            entry_we_q       <= 1'b0;
            index_wdata_q    <= 32'd0;
            entryhi_wdata_q  <= 32'd0;
            entrylo0_wdata_q <= 32'd0;
            entrylo1_wdata_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            config_q         <= config_d;
            index_q          <= index_d;
            op_ready_q       <= op_ready_d;
            op_done_q        <= op_done_d;
            tlb_we_q         <= tlb_we_d;
            tlb_p_q          <= tlb_p_d;
            index_we_q       <= index_we_d;
            entry_we_q       <= entry_we_d;
            index_wdata_q    <= index_wdata_d;
            entryhi_wdata_q  <= entryhi_wdata_d;
            entrylo0_wdata_q <= entrylo0_wdata_d;
            entrylo1_wdata_q <= entrylo1_wdata_d;
        end
    end

    assign op_ready         = op_ready_q;
    assign op_done          = op_done_q;
    assign random_o         = {{(32-TLB_WIDTH){1'b0}}, random_s};
    assign tlb_config       = config_q;
    assign tlb_config_index = index_q;
    assign tlb_rd_index     = index_q;
    assign tlb_we           = tlb_we_q;
    assign tlb_p            = tlb_p_q;
    assign index_we         = index_we_q;
    assign index_wdata      = index_wdata_q;
    assign entry_we         = entry_we_q;
    assign entryhi_wdata    = entryhi_wdata_q;
    assign entrylo0_wdata   = entrylo0_wdata_q;
    assign entrylo1_wdata   = entrylo1_wdata_q;

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
CP0-side sequencer for the MIPS TLB maintenance instructions TLBR, TLBWI, TLBWR and TLBP.
- Sits directly upstream of the TLB array. It packs CP0 EntryHi/EntryLo0/EntryLo1 into the 86-bit entry format and drives the TLB write and probe interface.
- Consumes the probe result and the TLB read port, and returns write-back data to CP0 Index/EntryHi/EntryLo0/EntryLo1.
- Owns the Random register.

Parameters:
TLB_ENTRIES, 16, number of TLB entries (power of 2)
TLB_WIDTH, 4, log2(TLB_ENTRIES), index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_valid  in  1  pipeline requests a TLB op
op_type  in  2  0=TLBR, 1=TLBWI, 2=TLBWR, 3=TLBP
op_ready  out  1  high only in IDLE
op_done  out  1  one-cycle pulse; the op has completed and write-back is valid
cp0_entryhi  in  32  [31:13] VPN2, [7:0] ASID
cp0_entrylo0  in  32  [25:6] PFN, [5:3] C, [2] D, [1] V, [0] G
cp0_entrylo1  in  32  same layout, odd page
cp0_index  in  32  [TLB_WIDTH-1:0] used
cp0_wired  in  32  [TLB_WIDTH-1:0] used; value >= TLB_ENTRIES is treated as TLB_ENTRIES-1
cp0_wired_we  in  1  CP0 Wired is being written this cycle
random_o  out  32  CP0 Random value, zero-extended
tlb_config  out  86  entry to write / probe key
tlb_config_index  out  TLB_WIDTH  write index
tlb_we  out  1  write strobe
tlb_p  out  1  probe strobe
tlb_p_res  in  32  [31] miss, [TLB_WIDTH-1:0] matching index
tlb_rd_index  out  TLB_WIDTH  read-port index
tlb_rd_entry  in  86  combinational read data
index_we  out  1  write-back strobe for CP0 Index
index_wdata  out  32  CP0 Index write-back data
entry_we  out  1  write-back strobe for EntryHi/EntryLo0/EntryLo1
entryhi_wdata  out  32  CP0 EntryHi write-back data
entrylo0_wdata  out  32  CP0 EntryLo0 write-back data
entrylo1_wdata  out  32  CP0 EntryLo1 write-back data

Behaviour:
Entry format (86 bits):
- [85:78] ASID
- [77] G, set to lo0.G & lo1.G
- [76:71] zero
- [70:52] VPN2
- [51:27] {PFN1,C1,D1,V1}
- [26] zero
- [25:1] {PFN0,C0,D0,V0}
- [0] zero

TLBR unpacks the entry as follows:
- entryhi = {VPN2, 5'b0, ASID}
- entrylo0 = {6'b0, PFN0, C0, D0, V0, G}
- entrylo1 = {6'b0, PFN1, C1, D1, V1, G}

FSM states: IDLE, EXEC, WB.
- IDLE: op_ready=1. When op_valid, latch op_type, the packed entry, and the index (cp0_index for TLBR/TLBWI, Random for TLBWR, both sampled this cycle), then go to EXEC.
- EXEC (1 cycle):
  - TLBWI/TLBWR: tlb_we=1 with the latched config and index.
  - TLBP: tlb_p=1 with the latched config; register tlb_p_res.
  - TLBR: tlb_rd_index = latched index; register tlb_rd_entry.
  - Then go to WB.
- WB (1 cycle): op_done=1.
  - TLBP: index_we=1, index_wdata = {miss, 0..., idx}; idx is forced to 0 when miss=1.
  - TLBR: entry_we=1 with the unpacked values.
  - Writes: no write-back.
  - Then return to IDLE.

Timing:
- Total latency is 3 cycles from acceptance to op_done.
- Back-to-back ops are accepted every 3 cycles.
- op_valid is ignored outside IDLE.

Random register:
- Reset value is TLB_ENTRIES-1.
- Decrements every cycle.
- When Random == wired and it would decrement, it wraps to TLB_ENTRIES-1.
- cp0_wired_we forces Random to TLB_ENTRIES-1 the next cycle; this has priority over the decrement.
- If wired is 0, Random cycles the full range.
- The TLBWR index is Random as sampled on the acceptance cycle.

Reset:
- All strobes (tlb_we, tlb_p, op_done, index_we, entry_we) are 0; all data outputs are 0; state is IDLE; Random is TLB_ENTRIES-1.
- Reset mid-operation abandons the op with no strobe and no write-back.

Outputs are registered; tlb_config and tlb_config_index hold their latched values outside EXEC.

Decomposition:
- Shared package tlb_pkg holds:
  - op-type enum;
  - entry-field bit-position constants;
  - TLB_ENTRIES/TLB_WIDTH defaults;
  - functions pack_entry(hi, lo0, lo1) and unpack_entry(entry).
- One sub-module, tlb_random: the Random counter, with wired and wired_we inputs and a random output.

Test Plan:
- Reset, then idle for 20 cycles -> random_o steps 15,14,…,0,15; no strobes are asserted.
- Write cp0_wired=4 with wired_we -> next cycle Random=15; the sequence then runs 15..4,15; wired=20 holds Random at 15.
- TLBWI with index=3, entryhi=0x0040_2005, lo0=0x0000_0047, lo1=0x0000_0087 -> tlb_we high exactly one cycle, 2 cycles after acceptance; tlb_config_index=3; config[70:52]=0x00201, [85:78]=0x05, [77]=1; op_done fires the following cycle.
- TLBP with tlb_p_res=0x0000_0003 -> index_wdata=0x0000_0003. With tlb_p_res=0x8000_0007 -> index_wdata=0x8000_0000.
- TLBR index 3 with the entry written above -> entryhi_wdata=0x0040_2005, entrylo0_wdata=0x0000_0047, entrylo1_wdata=0x0000_0087 (reads back identically); entry_we pulses once.
- Assert rst during EXEC of TLBWR -> no tlb_we and no op_done; op_ready=1 after reset.
